// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Takes one serial transfer per valid/ready handshake and steps a universal
// shift register through it by driving the register's 3-bit control port.
// TX: one parallel-load cycle, then N shifts. RX: N shifts only, so the
// received word is left in the register.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   req_valid    transfer request (accepted in IDLE)
//   req_ready    high in IDLE
//   req_mode     0 = TX (load then shift), 1 = RX (shift only), sampled at accept
//   req_dir      0 = shift right, 1 = shift left, sampled at accept
//   shift_en     0 stalls SHIFT (register held, counter frozen)
//   abort        cancels a transfer that is in LOAD or SHIFT
//   ur_ctrl      control code to the shift register
//   bit_strobe   high in cycles whose closing posedge performs a shift
//   shift_count  shifts remaining (non-zero only in SHIFT)
//   busy         high in any state other than IDLE
//   done         one-cycle pulse, transfer completed
//   aborted      one-cycle pulse, transfer cancelled
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int         N         = 4,
  parameter int         CW        = $clog2(N + 1),
  parameter logic [2:0] CTRL_HOLD = 3'd0,
  parameter logic [2:0] CTRL_SHR  = 3'd1,
  parameter logic [2:0] CTRL_SHL  = 3'd2,
  parameter logic [2:0] CTRL_LOAD = 3'd3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_mode,
  input  logic          req_dir,
  input  logic          shift_en,
  input  logic          abort,
  output logic [2:0]    ur_ctrl,
  output logic          bit_strobe,
  output logic [CW-1:0] shift_count,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q;
  logic          dir_q;
  logic [CW-1:0] cnt_q;
  logic          aborted_q;

  // The request mode only selects the first state after accept (LOAD for TX,
  // SHIFT for RX); from then on the state itself carries that information.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort has no effect here; a request is still accepted
          if (req_valid) begin
            dir_q   <= req_dir;
            cnt_q   <= CNT_FULL;
            state_q <= req_mode ? S_SHIFT : S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
          end else if (shift_en && (cnt_q != '0)) begin
            // guard on non-zero keeps the counter from ever wrapping
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; only the SHIFT control code and
  // strobe also look at shift_en, so a stall holds the register that cycle.
  always_comb begin
    ur_ctrl     = CTRL_HOLD;
    bit_strobe  = 1'b0;
    shift_count = '0;
    case (state_q)
      S_LOAD: begin
        ur_ctrl = CTRL_LOAD;
      end
      S_SHIFT: begin
        shift_count = cnt_q;
        if (shift_en) begin
          ur_ctrl    = dir_q ? CTRL_SHL : CTRL_SHR;
          bit_strobe = 1'b1;
        end
      end
      default: begin
        ur_ctrl = CTRL_HOLD;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_mode;
  logic          req_dir;
  logic          shift_en;
  logic          abort;
  logic [2:0]    ur_ctrl;
  logic          bit_strobe;
  logic [CW-1:0] shift_count;
  logic          busy;
  logic          done;
  logic          aborted;

  int n_tests;
  int n_fail;

  shift_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_dir    (req_dir),
    .shift_en   (shift_en),
    .abort      (abort),
    .ur_ctrl    (ur_ctrl),
    .bit_strobe (bit_strobe),
    .shift_count(shift_count),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to just after the next active edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic d,
                       input logic se, input logic ab);
    req_valid = v; req_mode = m; req_dir = d; shift_en = se; abort = ab;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Directed per-cycle vectors: inputs for the cycle and the outputs expected
  // in that same cycle (sampled at the falling edge).
  typedef struct {
    logic       v, m, d, se, ab;
    logic [2:0] ur;
    int         sc;
    logic       bs, bsy, dn, rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic m, logic d, logic se, logic ab,
                              logic [2:0] ur, int sc, logic bs, logic bsy,
                              logic dn, logic rdy);
    vec_t r;
    r.v = v; r.m = m; r.d = d; r.se = se; r.ab = ab;
    r.ur = ur; r.sc = sc; r.bs = bs; r.bsy = bsy; r.dn = dn; r.rdy = rdy;
    return r;
  endfunction

  // Reference model: tracks the outstanding work of a transfer as counts.
  int   m_load_left;
  int   m_shifts_left;
  int   m_done_due;
  int   m_aborted;
  int   m_dir;

  function automatic int m_idle();
    return (m_load_left == 0 && m_shifts_left == 0 && m_done_due == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_load_left = 0; m_shifts_left = 0; m_done_due = 0; m_aborted = 0; m_dir = 0;
  endtask

  task automatic model_edge(input logic v, input logic m, input logic d,
                            input logic se, input logic ab);
    int ab_next;
    ab_next = 0;
    if (m_idle() == 1) begin
      if (v) begin
        m_dir = d;
        m_load_left = m ? 0 : 1;
        m_shifts_left = N;
      end
    end else if (m_done_due == 1) begin
      m_done_due = 0;
    end else if (ab) begin
      m_load_left = 0;
      m_shifts_left = 0;
      ab_next = 1;
    end else if (m_load_left == 1) begin
      m_load_left = 0;
    end else if (se) begin
      m_shifts_left--;
      if (m_shifts_left == 0) m_done_due = 1;
    end
    m_aborted = ab_next;
  endtask

  task automatic model_check(input int cyc);
    int e_ur, e_sc, e_bs, shifting;
    shifting = (m_load_left == 0 && m_shifts_left > 0) ? 1 : 0;
    e_ur = (m_load_left == 1) ? 3 : (shifting == 1 && shift_en) ? (m_dir ? 2 : 1) : 0;
    e_bs = (shifting == 1 && shift_en) ? 1 : 0;
    e_sc = (shifting == 1) ? m_shifts_left : 0;
    chk("rnd_ur_ctrl", int'(ur_ctrl), e_ur);
    chk("rnd_shift_count", int'(shift_count), e_sc);
    chk("rnd_bit_strobe", int'(bit_strobe), e_bs);
    chk("rnd_busy", int'(busy), 1 - m_idle());
    chk("rnd_req_ready", int'(req_ready), m_idle());
    chk("rnd_done", int'(done), m_done_due);
    chk("rnd_aborted", int'(aborted), m_aborted);
    $display("[TB] rnd cyc %0d v=%0b m=%0b d=%0b se=%0b ab=%0b ur=%0d sc=%0d busy=%0b done=%0b abt=%0b",
             cyc, req_valid, req_mode, req_dir, shift_en, abort, ur_ctrl,
             shift_count, busy, done, aborted);
  endtask

  initial begin
    int strobes, busy_cycles, done_cyc, seen_pulse;
    n_tests = 0;
    n_fail  = 0;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1, 0, 0, 1, 1);  // activity on inputs must not matter in reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ur_ctrl", int'(ur_ctrl), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_shift_count", int'(shift_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    drive(0, 0, 0, 1, 0);
    rst_n = 1'b1;
    next_cycle();
    chk("rst_rel_busy", int'(busy), 0);
    chk("rst_rel_done", int'(done | aborted), 0);
    $display("[TB] reset checked");

    // ---------------- table-driven vectors ----------------
    //                v  m  d  se ab  ur  sc bs bsy dn rdy
    // TX right, no stalls
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0)); // LOAD ignores shift_en
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // RX left, two stall cycles after the second shift
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    strobes = 0;
    busy_cycles = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].m, vecs[i].d, vecs[i].se, vecs[i].ab);
      @(negedge clk);
      chk("vec_ur_ctrl", int'(ur_ctrl), int'(vecs[i].ur));
      chk("vec_shift_count", int'(shift_count), vecs[i].sc);
      chk("vec_bit_strobe", int'(bit_strobe), int'(vecs[i].bs));
      chk("vec_busy", int'(busy), int'(vecs[i].bsy));
      chk("vec_done", int'(done), int'(vecs[i].dn));
      chk("vec_req_ready", int'(req_ready), int'(vecs[i].rdy));
      chk("vec_aborted", int'(aborted), 0);
      if (i < 8) strobes += int'(bit_strobe);
      else busy_cycles += int'(busy);
      $display("[TB] vec %0d ur=%0d sc=%0d bs=%0b busy=%0b done=%0b",
               i, ur_ctrl, shift_count, bit_strobe, busy, done);
      next_cycle();
    end
    chk("tx_strobe_total", strobes, N);
    chk("rx_busy_total", busy_cycles, 7);

    // ---------------- abort during SHIFT ----------------
    drive(1, 1, 0, 1, 0);           // RX right
    next_cycle();
    drive(0, 0, 0, 1, 0);
    next_cycle();                   // sc=4
    next_cycle();                   // sc=3
    @(negedge clk);
    chk("abt_pre_count", int'(shift_count), 2);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    req_valid = 1'b1; req_mode = 1'b0;  // new TX straight away
    @(negedge clk);
    chk("abt_ur_ctrl", int'(ur_ctrl), 0);
    chk("abt_ready", int'(req_ready), 1);
    chk("abt_pulse", int'(aborted), 1);
    chk("abt_no_done", int'(done), 0);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("abt_pulse_end", int'(aborted), 0);
    chk("abt_new_load", int'(ur_ctrl), 3);
    seen_pulse = 0;
    abort = 1'b1;                   // abort in LOAD as well
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    chk("abt_load_pulse", int'(aborted), 1);
    chk("abt_load_idle", int'(busy), 0);
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      seen_pulse |= int'(done) | int'(aborted);
    end
    chk("abt_quiet_after", seen_pulse, 0);
    $display("[TB] abort sequence checked");

    // ---------------- back-to-back TX ----------------
    next_cycle();
    drive(1, 0, 0, 1, 0);
    done_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        chk("b2b_idle_between", int'(req_ready), 1);
        chk("b2b_idle_ur", int'(ur_ctrl), 0);
      end
      if (done_cyc >= 0 && c == done_cyc + 2) begin
        chk("b2b_second_load", int'(ur_ctrl), 3);
        req_valid = 1'b0;
      end
      next_cycle();
    end
    chk("b2b_done_seen", done_cyc, N + 2);
    $display("[TB] back-to-back checked, first done at cycle %0d", done_cyc);
    do_reset();

    // ---------------- reset mid-LOAD ----------------
    drive(1, 0, 1, 1, 0);
    next_cycle();
    req_valid = 1'b0;
    #2;
    chk("rl_in_load", int'(ur_ctrl), 3);
    rst_n = 1'b0;
    #1;
    chk("rl_ur_async", int'(ur_ctrl), 0);
    chk("rl_ready_async", int'(req_ready), 1);
    chk("rl_busy_async", int'(busy), 0);
    chk("rl_count_async", int'(shift_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_pulse = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      seen_pulse |= int'(done) | int'(aborted) | int'(busy);
    end
    chk("rl_quiet_after", seen_pulse, 0);
    $display("[TB] reset mid-LOAD checked");

    // ---------------- randomized vs reference model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_edge(req_valid, req_mode, req_dir, shift_en, abort);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller that sequences the team's universal shift register through complete serial transfers. A requester issues one transfer per valid/ready handshake: TX (parallel load, then N shifts out) or RX (N shifts in, word left in the register). The block drives the register's 3-bit control port. It sits between a bus-side requester and one universal register instance, sharing the same clock and reset.

## Interface
- N, 4: register width; number of shifts per transfer (N >= 1)
- CW, $clog2(N+1): width of the shift counter and `shift_count`
- CTRL_HOLD, 3'd0: register control code, hold
- CTRL_SHR, 3'd1: register control code, shift right
- CTRL_SHL, 3'd2: register control code, shift left
- CTRL_LOAD, 3'd3: register control code, parallel load

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  transfer request
- req_ready  out  1  high when a request can be accepted (state IDLE)
- req_mode  in  1  0 = TX (load then shift), 1 = RX (shift only); sampled at accept
- req_dir  in  1  0 = shift right, 1 = shift left; sampled at accept
- shift_en  in  1  stall control; 0 freezes SHIFT state (register held)
- abort  in  1  cancels an in-flight transfer
- ur_ctrl  out  3  drives register control input
- bit_strobe  out  1  high in cycles whose closing posedge performs a shift
- shift_count  out  CW  shifts remaining in the current transfer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, transfer completed
- aborted  out  1  one-cycle pulse, transfer cancelled

## Operation
- States: IDLE, LOAD, SHIFT, DONE. State, mode, dir, counter and `aborted` are registered. Other outputs decode from state.
- IDLE: req_ready=1, ur_ctrl=CTRL_HOLD. `req_valid` at a posedge is an accept: latch mode and dir, counter<=N. Next state is LOAD for TX, SHIFT for RX.
- LOAD: ur_ctrl=CTRL_LOAD for exactly one cycle, then SHIFT. `shift_en` is ignored in LOAD.
- SHIFT, shift_en=1: ur_ctrl = CTRL_SHR (dir=0) or CTRL_SHL (dir=1), bit_strobe=1, counter decrements. If counter==1, next state is DONE.
- SHIFT, shift_en=0: ur_ctrl=CTRL_HOLD, bit_strobe=0, counter and state frozen.
- DONE: ur_ctrl=CTRL_HOLD, done=1 for one cycle, then IDLE.
- shift_count = counter in SHIFT. It is 0 in IDLE, LOAD and DONE.
- abort=1 in LOAD or SHIFT has priority over all other transitions:
  - next state IDLE, counter<=0;
  - ur_ctrl is CTRL_HOLD from the next cycle;
  - `aborted` is high the following cycle; `done` is not asserted.
- abort is ignored in IDLE and DONE. In IDLE, abort together with req_valid still accepts the request.
- Unused control codes (4–7) are never driven.

## Timing
- Reset (asynchronous, rst_n=0) values:
  - state=IDLE, counter=0, latched mode/dir=0;
  - ur_ctrl=CTRL_HOLD, req_ready=1, busy=0, done=0, aborted=0, bit_strobe=0, shift_count=0.
- Reset asserted mid-transfer returns to IDLE immediately, with no done or aborted pulse.
- Request accepted at posedge k. Next cycle is LOAD (TX) or SHIFT (RX).
- TX with no stalls: busy for N+2 cycles (1 LOAD, N SHIFT, 1 DONE). done is high in cycle k+N+2; req_ready is high again in cycle k+N+3.
- RX with no stalls: busy for N+1 cycles. done is high in cycle k+N+1.
- Each stall cycle (shift_en=0 in SHIFT) adds exactly one cycle and no shift.
- Back-to-back: the earliest next accept is the posedge ending the first IDLE cycle after DONE. There is no accept during DONE.
- The counter never wraps. It is only decremented when it is >= 1.

## Test plan
- Reset: hold rst_n=0 with clk toggling, then release → ur_ctrl=3'd0, req_ready=1, busy=0, shift_count=0; no done or aborted pulses.
- TX right, N=4, shift_en=1, request at posedge k:
  - ur_ctrl sequence per cycle: 3,1,1,1,1,0;
  - shift_count: 0,4,3,2,1,0;
  - done high only in cycle k+6; bit_strobe high for exactly 4 cycles.
- RX left, N=4, with shift_en low for 2 cycles after the second shift → ur_ctrl sequence 2,2,0,0,2,2,0, then done; busy for 7 cycles.
- Abort during SHIFT with shift_count=2 → next cycle IDLE, ur_ctrl=0, aborted=1 for one cycle, done never high. A new request is accepted immediately afterwards.
- Back-to-back: req_valid held high for two TX transfers → second LOAD begins 2 cycles after the first done cycle (one IDLE accept cycle between them).
- Reset pulse mid-LOAD → outputs return to reset values asynchronously, with no done or aborted pulse.
